// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and helpers for the instruction-fetch front end.
// The BTB is only built when FETCH_BTB_EN is defined; see fetch_unit.
package fetch_pkg;

  // 2-bit saturating branch counter; bit 1 set means "predict taken".
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  // Per-entry control state. Tag and target widths depend on the btb
  // parameters, so those fields live in parallel arrays inside btb.
  typedef struct packed {
    logic valid;
    cnt_e cnt;
  } btb_meta_t;

  // Bubble inserted into IF/ID on a redirect.
  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - 2 - $clog2(entries);
  endfunction

  function automatic cnt_e cnt_inc(input cnt_e c);
    return (c == CNT_ST) ? CNT_ST : cnt_e'(c + 2'd1);
  endfunction

  function automatic cnt_e cnt_dec(input cnt_e c);
    return (c == CNT_SNT) ? CNT_SNT : cnt_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// btb: direct-mapped branch target buffer with 2-bit counters.
// Addresses arrive as word addresses (byte offset stripped). Lookup is purely
// combinational on stored state, so a same-cycle update is not visible to it.
module btb
  import fetch_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-3:0] lookup_word,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_en,
  input  logic [XLEN-3:0] upd_word,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);
  localparam int IDX = idx_w(ENTRIES);
  localparam int TAG = tag_w(XLEN, ENTRIES);

  btb_meta_t       meta  [ENTRIES];
  logic [TAG-1:0]  tag_q [ENTRIES];
  logic [XLEN-1:0] tgt_q [ENTRIES];

  logic [IDX-1:0] l_idx, u_idx;
  logic [TAG-1:0] l_tag, u_tag;
  logic           l_hit, u_hit;

  assign l_idx = lookup_word[IDX-1:0];
  assign l_tag = lookup_word[XLEN-3:IDX];
  assign u_idx = upd_word[IDX-1:0];
  assign u_tag = upd_word[XLEN-3:IDX];

  assign l_hit = meta[l_idx].valid && (tag_q[l_idx] == l_tag);
  assign u_hit = meta[u_idx].valid && (tag_q[u_idx] == u_tag);

  // Predict taken only on a tag hit with the counter in a taken state.
  assign pred_taken  = l_hit && (meta[l_idx].cnt inside {CNT_WT, CNT_ST});
  assign pred_target = pred_taken ? tgt_q[l_idx] : '0;

  // Valid/counter state: cleared on reset, trained on resolve.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) meta[i] <= '{valid: 1'b0, cnt: CNT_WNT};
    end else if (upd_en) begin
      if (u_hit)
        meta[u_idx].cnt <= upd_taken ? cnt_inc(meta[u_idx].cnt) : cnt_dec(meta[u_idx].cnt);
      else if (upd_taken)
        meta[u_idx] <= '{valid: 1'b1, cnt: CNT_WT};
    end
  end

  // Tag/target payload: a taken resolve either refreshes a hit or allocates,
  // and in both cases the tag equals u_tag, so one write covers both.
  always_ff @(posedge clk) begin
    if (reset && upd_en && upd_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID register and decode-stage redirect for the
// 5-stage MIPS pipeline. Define FETCH_BTB_EN to add the branch target buffer;
// without it the front end always predicts fall-through.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            stall_d,
  output logic [XLEN-1:0] pc_f,
  input  logic [31:0]     instr_f,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            pred_taken_d,
  output logic [XLEN-1:0] pred_target_d,
  input  logic            resolve_valid,
  input  logic            resolve_taken,
  input  logic [XLEN-1:0] resolve_target,
  output logic            mispredict_d
);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] pc_plus4_f, pred_next_f, redirect_pc, pred_target_f;
  logic            pred_taken_f, res_en;

  assign pc_plus4_f = pc_f + FOUR;

`ifdef FETCH_BTB_EN
  btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .lookup_word (pc_f[XLEN-1:2]),
    .pred_taken  (pred_taken_f),
    .pred_target (pred_target_f),
    .upd_en      (res_en),
    .upd_word    (pc_d[XLEN-1:2]),
    .upd_taken   (resolve_taken),
    .upd_target  (resolve_target)
  );
`else
  assign pred_taken_f  = 1'b0;
  assign pred_target_f = '0;
`endif

  assign pred_next_f = pred_taken_f ? pred_target_f : pc_plus4_f;

  // A resolve only counts for a real instruction that decode is consuming.
  assign res_en       = resolve_valid & valid_d & ~stall_d;
  assign mispredict_d = res_en & ((resolve_taken != pred_taken_d) |
                                  (resolve_taken & (resolve_target != pred_target_d)));
  assign redirect_pc  = resolve_taken ? resolve_target : pc_plus4_d;

  // PC: reset > redirect > hold > predicted next.
  always_ff @(posedge clk) begin
    if (!reset)            pc_f <= RESET_PC;
    else if (mispredict_d) pc_f <= redirect_pc;
    else if (!stall_f)     pc_f <= pred_next_f;
  end

  // IF/ID: a redirect flushes even under stall_d; otherwise hold or capture.
  always_ff @(posedge clk) begin
    if (!reset || mispredict_d) begin
      instr_d       <= NOP;
      pc_d          <= '0;
      pc_plus4_d    <= '0;
      valid_d       <= 1'b0;
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
    end else if (!stall_d) begin
      instr_d       <= instr_f;
      pc_d          <= pc_f;
      pc_plus4_d    <= pc_plus4_f;
      valid_d       <= 1'b1;
      pred_taken_d  <= pred_taken_f;
      pred_target_d <= pred_target_f;
    end
  end

endmodule
